dmem_responder: RTL and testbench

Data-memory responder sitting on the far side of the core's load/store port: accepts one word-level read or byte-masked write request at a time, inserts a programmable number of wait states, performs the access, and returns a single-cycle response. It replaces the zero-latency data array so the pipeline's stall and hold logic can be exercised against a memory that does not answer combinationally. Byte/half-word extraction and sign extension stay in the core; this block only moves aligned 32-bit words under a byte mask.

---
 rtl/dmem_pkg.sv | 6 +
 rtl/dmem_array.sv | 24 ++
 rtl/dmem_responder.sv | 81 ++++++++
 tb/tb_dmem_responder.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and widths for the data-memory responder.
package dmem_pkg;
    localparam int WORD_W = 32;
    localparam int LANES  = 4;
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: synchronous word array with byte-enable write and registered read.
module dmem_array import dmem_pkg::*; #(
    parameter int DEPTH = 1024,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [AW-1:0]     i_addr,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic [LANES-1:0]  i_mask,
    output logic [WORD_W-1:0] o_rdata
);
    logic [WORD_W-1:0] r_mem [DEPTH];
    // No reset: contents survive reset by design.
    always_ff @(posedge clk) begin
        if (i_en && i_we) begin
            for (int b = 0; b < LANES; b++)
                if (i_mask[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end else if (i_en) begin
            o_rdata <= r_mem[i_addr];
        end
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: one-at-a-time word memory with programmable wait states
// and a single-cycle response strobe.
module dmem_responder import dmem_pkg::*; #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [LANES-1:0]  req_mask,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic              r_we;
    logic [29:0]       r_idx;
    logic [WORD_W-1:0] r_wdata;
    logic [LANES-1:0]  r_mask;
    logic              r_rd_ok;
    logic              w_idle, w_commit, w_we, w_oob;
    logic [29:0]       w_idx;
    logic [WORD_W-1:0] w_wdata, w_rdata;
    logic [LANES-1:0]  w_mask;
    logic              w_unused;
    assign w_unused = &{1'b0, req_addr[1:0]};
    // With zero latency the access commits on the accept edge, so the array sees the live request.
    assign w_idle   = r_state == IDLE;
    assign w_idx    = w_idle ? req_addr[31:2] : r_idx;
    assign w_we     = w_idle ? req_we : r_we;
    assign w_wdata  = w_idle ? req_wdata : r_wdata;
    assign w_mask   = w_idle ? req_mask : r_mask;
    assign w_oob    = {2'b00, w_idx} >= 32'(DEPTH_WORDS);
    assign w_commit = ~reset & (w_idle ? req_valid & (LATENCY == 0)
                                       : (r_state == WAIT) & (r_cnt == CW'(1)));
    assign req_ready = w_idle;
    assign rsp_valid = r_state == RESP;
    assign rsp_rdata = r_rd_ok ? w_rdata : '0;
    dmem_array #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_array (
        .clk     (clk),
        .i_en    (w_commit & ~w_oob),
        .i_we    (w_we),
        .i_addr  (w_idx[AW-1:0]),
        .i_wdata (w_wdata),
        .i_mask  (w_mask),
        .o_rdata (w_rdata)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rd_ok <= 1'b0;
            rsp_err <= 1'b0;
        end else begin
            if (w_commit) begin
                r_rd_ok <= ~w_we & ~w_oob;
                rsp_err <= w_oob;
            end
            if (w_idle && req_valid) begin
                r_we    <= req_we;
                r_idx   <= req_addr[31:2];
                r_wdata <= req_wdata;
                r_mask  <= req_mask;
                r_cnt   <= CW'(LATENCY);
                r_state <= (LATENCY == 0) ? RESP : WAIT;
            end else if (r_state == WAIT) begin
                r_cnt   <= r_cnt - CW'(1);
                r_state <= (r_cnt == CW'(1)) ? RESP : WAIT;
            end else if (r_state == RESP) begin
                r_state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks of two responders
// (LATENCY 2 and 0) against a word-array reference model.
module tb_dmem_responder;
    localparam int D = 64;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  mask = '0;
    logic [1:0]  v = '0;
    logic [1:0]  rdy, rv, err;
    logic [31:0] rd [2];
    logic [31:0] mdl [2][D];
    int n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(D), .LATENCY(2)) u0 (
        .clk(clk), .reset(reset), .req_valid(v[0]), .req_ready(rdy[0]), .req_we(we),
        .req_addr(addr), .req_wdata(wdata), .req_mask(mask),
        .rsp_valid(rv[0]), .rsp_rdata(rd[0]), .rsp_err(err[0]));
    dmem_responder #(.DEPTH_WORDS(D), .LATENCY(0)) u1 (
        .clk(clk), .reset(reset), .req_valid(v[1]), .req_ready(rdy[1]), .req_we(we),
        .req_addr(addr), .req_wdata(wdata), .req_mask(mask),
        .rsp_valid(rv[1]), .rsp_rdata(rd[1]), .rsp_err(err[1]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int lat(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    // One transaction: checks acceptance, busy window, latency, response, single-cycle strobe.
    task automatic txn(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m);
        int n, idx;
        bit oob;
        @(negedge clk);
        we = w; addr = a; wdata = d; mask = m; v[k] = 1'b1;
        n = 0;
        while (!rdy[k] && n < 20) begin @(negedge clk); n++; end
        if (!rdy[k]) begin
            check("ready_timeout", 0, 1);
            v[k] = 1'b0;
            return;
        end
        oob = a[31:2] >= D;
        idx = int'(a[7:2]);
        @(negedge clk);
        v[k] = 1'b0;
        n = 1;
        while (!rv[k] && n < 20) begin
            check("ready_busy", 32'(rdy[k]), 0);
            @(negedge clk);
            n++;
        end
        check("ready_in_resp", 32'(rdy[k]), 0);
        check("latency", n, lat(k) + 1);
        check("rsp_err", 32'(err[k]), 32'(oob));
        check("rsp_rdata", rd[k], (w || oob) ? 32'h0 : mdl[k][idx]);
        if (w && !oob)
            for (int b = 0; b < 4; b++)
                if (m[b]) mdl[k][idx][8*b +: 8] = d[8*b +: 8];
        @(negedge clk);
        check("rsp_one_cycle", 32'(rv[k]), 0);
        check("ready_back", 32'(rdy[k]), 1);
    endtask

    // Hold req_valid high across three full transaction periods.
    task automatic hold(input int k);
        int acc = 0, rs = 0, p;
        p = 3 * (lat(k) + 2);
        @(negedge clk);
        we = 1'b0; addr = 32'h0; v[k] = 1'b1;
        for (int i = 0; i < p; i++) begin
            if (v[k] && rdy[k]) acc++;
            if (rv[k]) rs++;
            if (i < p - 1) @(negedge clk);
        end
        v[k] = 1'b0;
        check("hold_accepts", acc, 3);
        check("hold_responses", rs, 3);
        @(negedge clk);
        check("hold_quiet", 32'(rv[k]), 0);
    endtask

    // Reset nw cycles after the request is presented; the write must be dropped.
    task automatic reset_abort(input int k, input logic [31:0] a, input int nw);
        int cnt = 0;
        @(negedge clk);
        we = 1'b1; addr = a; wdata = 32'hFFFF_FFFF; mask = 4'hF; v[k] = 1'b1;
        if (nw == 0) reset = 1'b1;
        else begin
            @(negedge clk);
            v[k] = 1'b0;
            check("abort_busy", 32'(rdy[k]), 0);
            repeat (nw - 1) @(negedge clk);
            reset = 1'b1;
        end
        @(negedge clk);
        v[k] = 1'b0;
        check("abort_ready", 32'(rdy[k]), 1);
        check("abort_valid", 32'(rv[k]), 0);
        check("abort_rdata", rd[k], 0);
        check("abort_err", 32'(err[k]), 0);
        reset = 1'b0;
        repeat (6) begin @(negedge clk); if (rv[k]) cnt++; end
        check("abort_no_rsp", cnt, 0);
        txn(k, 1'b0, a, 32'h0, 4'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_ready", 32'(rdy[k]), 1);
            check("rst_valid", 32'(rv[k]), 0);
            check("rst_rdata", rd[k], 0);
            check("rst_err", 32'(err[k]), 0);
        end
        reset = 1'b0;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < D; i++) txn(k, 1'b1, 32'(i * 4), $urandom, 4'hF);
        txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0);
        check("read_deadbeef", rd[0], 32'hDEAD_BEEF);
        txn(0, 1'b1, 32'h10, 32'h0000_00AA, 4'b0001);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0);
        check("read_deadbeaa", rd[0], 32'hDEAD_BEAA);
        txn(1, 1'b1, 32'h20, 32'hCAFE_F00D, 4'hF);
        txn(1, 1'b0, 32'h20, 32'h0, 4'h0);
        check("lat0_raw", rd[1], 32'hCAFE_F00D);
        hold(1);
        hold(0);
        for (int k = 0; k < 2; k++) begin
            txn(k, 1'b0, 32'(4 * D), 32'h0, 4'h0);
            txn(k, 1'b1, 32'(4 * D + 3), 32'hFFFF_FFFF, 4'hF);
            txn(k, 1'b0, 32'h0, 32'h0, 4'h0);
            txn(k, 1'b1, 32'h40, $urandom, 4'h0);
            txn(k, 1'b0, 32'h40, 32'h0, 4'h0);
        end
        txn(0, 1'b1, 32'h30, 32'h1111_1111, 4'hF);
        reset_abort(0, 32'h30, 1);
        check("abort_word", rd[0], 32'h1111_1111);
        reset_abort(0, 32'h34, 2);
        reset_abort(1, 32'h38, 0);
        for (int i = 0; i < 200; i++) begin
            int k, word;
            k = int'($urandom_range(0, 1));
            word = int'($urandom_range(0, D + 15));
            txn(k, 1'($urandom), 32'(word * 4) | ($urandom & 32'h3), $urandom, 4'($urandom));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
